r_exec_ctrl: RTL and testbench

Multi-cycle execute sequencer for R-type instructions. Accepts one 32-bit instruction per handshake, reads the two source registers, drives the combinational R_ALU with the instruction, operands and shift amount, captures the result, and writes it back to the register file. It sits between the fetch/decode stage and the shared R_ALU/register-file pair, and serialises all R-type execution.

---
 rtl/r_exec_ctrl.sv | 140 ++++++++++++++
 tb/tb_r_exec_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r_exec_ctrl.sv
// r_exec_ctrl
//   Multi-cycle execute sequencer for R-type instructions. Accepts one
//   instruction per handshake, reads rs/rt from the register file, presents
//   the instruction and operands to the combinational R_ALU, captures the
//   result and writes it back to rd. Only one instruction is in flight at a
//   time, so write-back always completes before the next read.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   inst_valid/inst_ready   instruction handshake (ready only in IDLE)
//   inst_in                 32-bit instruction word
//   rf_raddr1/2, rf_rdata1/2  register-file read port (rs, rt)
//   alu_inst, alu_i1, alu_i2, alu_shift  R_ALU inputs
//   alu_out                 combinational R_ALU result
//   rf_we, rf_waddr, rf_wdata  register-file write port (rd)
//   busy                    high in every state except IDLE
//   done                    one-cycle pulse when an instruction retires
//   illegal                 one-cycle pulse when a non-R-type is rejected

module r_exec_ctrl #(
    parameter int RF_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [31:0] inst_in,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic [31:0] alu_inst,
    output logic [31:0] alu_i1,
    output logic [31:0] alu_i2,
    output logic [4:0]  alu_shift,
    input  logic [31:0] alu_out,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    // The counter counts the remaining read-latency cycles; a latency of 1
    // means the operands are latched on the first edge spent in READ.
    localparam logic [1:0] WAIT_INIT = 2'(RF_RD_LAT - 1);

    state_t      state;
    logic [31:0] inst_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic [31:0] result_q;
    logic [1:0]  wait_cnt;
    logic        we_q;
    logic        done_q;
    logic        illegal_q;

    // Everything the outside world sees is decoded from registers, so the
    // read address, ALU inputs and write port are glitch-free and hold
    // their values between instructions.
    assign inst_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign rf_raddr1  = inst_q[25:21];
    assign rf_raddr2  = inst_q[20:16];
    assign alu_inst   = inst_q;
    assign alu_i1     = op1_q;
    assign alu_i2     = op2_q;
    assign alu_shift  = inst_q[10:6];
    assign rf_waddr   = inst_q[15:11];
    assign rf_wdata   = result_q;
    assign rf_we      = we_q;
    assign done       = done_q;
    assign illegal    = illegal_q;

    // Single sequencer. The pulse outputs default low every cycle and are
    // set on the edge entering the cycle in which they must be visible:
    // done/rf_we on the EXEC->WB edge, illegal on the rejecting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            inst_q    <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            result_q  <= '0;
            wait_cnt  <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (inst_valid) begin
                        inst_q <= inst_in;
                        if (inst_in[31:26] == 6'd0) begin
                            wait_cnt <= WAIT_INIT;
                            state    <= READ;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (wait_cnt == 2'd0) begin
                        op1_q <= rf_rdata1;
                        op2_q <= rf_rdata2;
                        state <= EXEC;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                EXEC: begin
                    result_q <= alu_out;
                    done_q   <= 1'b1;
                    // r0 is hard-wired zero, so a write to it is suppressed
                    // while the instruction still retires normally.
                    we_q     <= (inst_q[15:11] != 5'd0);
                    state    <= WB;
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_r_exec_ctrl.sv
// tb_r_exec_ctrl
//   Directed bench for r_exec_ctrl. Instance dut_a uses a single-cycle
//   register file, dut_b a three-cycle one. Each instance has its own
//   register-file model and reference ALU model.

module tb_r_exec_ctrl;

    logic clk;
    logic rst_n;

    // Instance A (RF_RD_LAT = 1)
    logic        valid_a;
    logic        ready_a;
    logic [31:0] inst_a;
    logic [4:0]  raddr1_a, raddr2_a;
    logic [31:0] rdata1_a, rdata2_a;
    logic [31:0] alu_inst_a, alu_i1_a, alu_i2_a, alu_out_a;
    logic [4:0]  alu_shift_a;
    logic        we_a;
    logic [4:0]  waddr_a;
    logic [31:0] wdata_a;
    logic        busy_a, done_a, illegal_a;

    // Instance B (RF_RD_LAT = 3)
    logic        valid_b;
    logic        ready_b;
    logic [31:0] inst_b;
    logic [4:0]  raddr1_b, raddr2_b;
    logic [31:0] rdata1_b, rdata2_b;
    logic [31:0] alu_inst_b, alu_i1_b, alu_i2_b, alu_out_b;
    logic [4:0]  alu_shift_b;
    logic        we_b;
    logic [4:0]  waddr_b;
    logic [31:0] wdata_b;
    logic        busy_b, done_b, illegal_b;

    int errors;
    int checks;

    r_exec_ctrl #(.RF_RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .inst_valid(valid_a), .inst_ready(ready_a), .inst_in(inst_a),
        .rf_raddr1(raddr1_a), .rf_raddr2(raddr2_a),
        .rf_rdata1(rdata1_a), .rf_rdata2(rdata2_a),
        .alu_inst(alu_inst_a), .alu_i1(alu_i1_a), .alu_i2(alu_i2_a),
        .alu_shift(alu_shift_a), .alu_out(alu_out_a),
        .rf_we(we_a), .rf_waddr(waddr_a), .rf_wdata(wdata_a),
        .busy(busy_a), .done(done_a), .illegal(illegal_a)
    );

    r_exec_ctrl #(.RF_RD_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .inst_valid(valid_b), .inst_ready(ready_b), .inst_in(inst_b),
        .rf_raddr1(raddr1_b), .rf_raddr2(raddr2_b),
        .rf_rdata1(rdata1_b), .rf_rdata2(rdata2_b),
        .alu_inst(alu_inst_b), .alu_i1(alu_i1_b), .alu_i2(alu_i2_b),
        .alu_shift(alu_shift_b), .alu_out(alu_out_b),
        .rf_we(we_b), .rf_waddr(waddr_b), .rf_wdata(wdata_b),
        .busy(busy_b), .done(done_b), .illegal(illegal_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register contents after reset: r[i] = i, except r6 = all ones.
    function automatic logic [31:0] init_val(input int i);
        return (i == 6) ? 32'hFFFF_FFFF : 32'(i);
    endfunction

    // Reference R_ALU: funct selects the operation.
    function automatic logic [31:0] alu_model(input logic [31:0] inst,
                                              input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [4:0]  sh);
        case (inst[5:0])
            6'h20, 6'h21: return a + b;
            6'h22:        return a - b;
            6'h24:        return a & b;
            6'h25:        return a | b;
            6'h00:        return b << sh;
            default:      return a ^ b;
        endcase
    endfunction

    assign alu_out_a = alu_model(alu_inst_a, alu_i1_a, alu_i2_a, alu_shift_a);
    assign alu_out_b = alu_model(alu_inst_b, alu_i1_b, alu_i2_b, alu_shift_b);

    // Register file A: combinational read, write at the end of WB.
    logic [31:0] regs_a [32];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs_a[i] <= init_val(i);
        end else if (we_a) begin
            regs_a[waddr_a] <= wdata_a;
        end
    end
    assign rdata1_a = regs_a[raddr1_a];
    assign rdata2_a = regs_a[raddr2_a];

    // Register file B: address passes through two flops, so the data for a
    // new address is valid on the third edge after it appears.
    logic [31:0] regs_b [32];
    logic [4:0]  pa1, pb1, pa2, pb2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs_b[i] <= init_val(i);
            pa1 <= '0; pb1 <= '0; pa2 <= '0; pb2 <= '0;
        end else begin
            pa1 <= raddr1_b; pb1 <= pa1;
            pa2 <= raddr2_b; pb2 <= pa2;
            if (we_b) regs_b[waddr_b] <= wdata_b;
        end
    end
    assign rdata1_b = regs_b[pb1];
    assign rdata2_b = regs_b[pb2];

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic        exp_illegal;
        logic [4:0]  exp_ra1;
        logic [4:0]  exp_ra2;
        logic [31:0] exp_i1;
        logic [31:0] exp_i2;
        logic [4:0]  exp_shift;
        logic        exp_we;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives one instruction into instance A and checks every cycle up to
    // the first IDLE cycle after retirement (or after the illegal pulse).
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        checkOutput({v.name, " ready"}, 32'(ready_a), 32'd1);
        valid_a = 1'b1;
        inst_a  = v.inst;
        @(posedge clk);
        #1 valid_a = 1'b0;
        @(negedge clk);
        if (v.exp_illegal) begin
            checkOutput({v.name, " illegal"}, 32'(illegal_a), 32'd1);
            checkOutput({v.name, " rf_we"},   32'(we_a),      32'd0);
            checkOutput({v.name, " done"},    32'(done_a),    32'd0);
            checkOutput({v.name, " ready"},   32'(ready_a),   32'd1);
            checkOutput({v.name, " busy"},    32'(busy_a),    32'd0);
            @(negedge clk);
            checkOutput({v.name, " illegal end"}, 32'(illegal_a), 32'd0);
            checkOutput({v.name, " rf_we end"},   32'(we_a),      32'd0);
        end else begin
            checkOutput({v.name, " busy"},    32'(busy_a),    32'd1);
            checkOutput({v.name, " ready"},   32'(ready_a),   32'd0);
            checkOutput({v.name, " raddr1"},  32'(raddr1_a),  32'(v.exp_ra1));
            checkOutput({v.name, " raddr2"},  32'(raddr2_a),  32'(v.exp_ra2));
            checkOutput({v.name, " illegal"}, 32'(illegal_a), 32'd0);
            @(negedge clk);
            checkOutput({v.name, " alu_inst"},  alu_inst_a,       v.inst);
            checkOutput({v.name, " alu_i1"},    alu_i1_a,         v.exp_i1);
            checkOutput({v.name, " alu_i2"},    alu_i2_a,         v.exp_i2);
            checkOutput({v.name, " alu_shift"}, 32'(alu_shift_a), 32'(v.exp_shift));
            checkOutput({v.name, " early done"}, 32'(done_a),     32'd0);
            @(negedge clk);
            checkOutput({v.name, " done"},  32'(done_a),  32'd1);
            checkOutput({v.name, " rf_we"}, 32'(we_a),    32'(v.exp_we));
            checkOutput({v.name, " waddr"}, 32'(waddr_a), 32'(v.exp_waddr));
            checkOutput({v.name, " wdata"}, wdata_a,      v.exp_wdata);
            checkOutput({v.name, " done+illegal"}, 32'(illegal_a), 32'd0);
            @(negedge clk);
            checkOutput({v.name, " done end"}, 32'(done_a),  32'd0);
            checkOutput({v.name, " we end"},   32'(we_a),    32'd0);
            checkOutput({v.name, " ready end"}, 32'(ready_a), 32'd1);
        end
    endtask

    logic we_seen;

    initial begin
        errors  = 0;
        checks  = 0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        inst_a  = '0;
        inst_b  = '0;
        rst_n   = 1'b0;

        //             name        inst           ill ra1 ra2 i1            i2  sh we wa  wdata
        vecs[0] = '{"add",     32'h0022_1820, 1'b0, 5'd1, 5'd2, 32'd1,        32'd2, 5'd0, 1'b1, 5'd3,  32'd3};
        vecs[1] = '{"addu",    32'h0085_1821, 1'b0, 5'd4, 5'd5, 32'd4,        32'd5, 5'd0, 1'b1, 5'd3,  32'd9};
        vecs[2] = '{"sub",     32'h00C1_3822, 1'b0, 5'd6, 5'd1, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b1, 5'd7,  32'hFFFFFFFE};
        vecs[3] = '{"addwrap", 32'h00C2_4020, 1'b0, 5'd6, 5'd2, 32'hFFFFFFFF, 32'd2, 5'd0, 1'b1, 5'd8,  32'd1};
        vecs[4] = '{"sll",     32'h0005_48C0, 1'b0, 5'd0, 5'd5, 32'd0,        32'd5, 5'd3, 1'b1, 5'd9,  32'd40};
        vecs[5] = '{"illegal", 32'h8C22_1820, 1'b1, 5'd0, 5'd0, 32'd0,        32'd0, 5'd0, 1'b0, 5'd0,  32'd0};
        vecs[6] = '{"rd0",     32'h0022_0020, 1'b0, 5'd1, 5'd2, 32'd1,        32'd2, 5'd0, 1'b0, 5'd0,  32'd3};
        vecs[7] = '{"and",     32'h00C5_5024, 1'b0, 5'd6, 5'd5, 32'hFFFFFFFF, 32'd5, 5'd0, 1'b1, 5'd10, 32'd5};

        #3;
        checkOutput("reset ready",   32'(ready_a),   32'd1);
        checkOutput("reset busy",    32'(busy_a),    32'd0);
        checkOutput("reset done",    32'(done_a),    32'd0);
        checkOutput("reset illegal", 32'(illegal_a), 32'd0);
        checkOutput("reset rf_we",   32'(we_a),      32'd0);
        checkOutput("reset alu_i1",  alu_i1_a,       32'd0);
        checkOutput("reset wdata",   wdata_a,        32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // Back-to-back with dependency: A writes r13 = 4 + 5, B reads r13.
        // inst_valid stays high throughout; B must wait for A's write-back.
        @(negedge clk);
        valid_a = 1'b1;
        inst_a  = 32'h0085_6820;
        @(posedge clk);
        #1 inst_a = 32'h01A1_5820;
        @(negedge clk);
        checkOutput("dep A read ready", 32'(ready_a),  32'd0);
        @(negedge clk);
        checkOutput("dep A exec ready", 32'(ready_a),  32'd0);
        checkOutput("dep A raddr1",     32'(raddr1_a), 32'd4);
        checkOutput("dep A alu_inst",   alu_inst_a,    32'h0085_6820);
        @(negedge clk);
        checkOutput("dep A wb ready",   32'(ready_a),  32'd0);
        checkOutput("dep A done",       32'(done_a),   32'd1);
        checkOutput("dep A waddr",      32'(waddr_a),  32'd13);
        checkOutput("dep A wdata",      wdata_a,       32'd9);
        @(negedge clk);
        checkOutput("dep idle ready",   32'(ready_a),  32'd1);
        @(posedge clk);
        #1 valid_a = 1'b0;
        @(negedge clk);
        checkOutput("dep B raddr1",     32'(raddr1_a), 32'd13);
        @(negedge clk);
        checkOutput("dep B alu_i1",     alu_i1_a,      32'd9);
        @(negedge clk);
        checkOutput("dep B done",       32'(done_a),   32'd1);
        checkOutput("dep B waddr",      32'(waddr_a),  32'd11);
        checkOutput("dep B wdata",      wdata_a,       32'd10);

        // Reset asserted while in EXEC: outputs clear at once, no write.
        @(negedge clk);
        valid_a = 1'b1;
        inst_a  = 32'h0022_1820;
        @(posedge clk);
        #1 valid_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre-reset alu_i1", alu_i1_a, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid reset busy",     32'(busy_a),     32'd0);
        checkOutput("mid reset ready",    32'(ready_a),    32'd1);
        checkOutput("mid reset alu_i1",   alu_i1_a,        32'd0);
        checkOutput("mid reset alu_inst", alu_inst_a,      32'd0);
        checkOutput("mid reset raddr1",   32'(raddr1_a),   32'd0);
        checkOutput("mid reset done",     32'(done_a),     32'd0);
        we_seen = we_a;
        repeat (2) begin
            @(negedge clk);
            if (we_a) we_seen = 1'b1;
        end
        checkOutput("no we in reset", 32'(we_seen), 32'd0);
        rst_n = 1'b1;
        applyStimulus(vecs[0]);

        // Instance B, three-cycle read latency: r4 + r6 -> r12.
        @(negedge clk);
        valid_b = 1'b1;
        inst_b  = 32'h0086_6020;
        @(posedge clk);
        #1 valid_b = 1'b0;
        @(negedge clk);
        checkOutput("lat3 busy",   32'(busy_b),   32'd1);
        checkOutput("lat3 raddr1", 32'(raddr1_b), 32'd4);
        checkOutput("lat3 raddr2", 32'(raddr2_b), 32'd6);
        @(negedge clk);
        checkOutput("lat3 wait1 i1", alu_i1_b, 32'd0);
        @(negedge clk);
        checkOutput("lat3 wait2 i1", alu_i1_b, 32'd0);
        checkOutput("lat3 wait2 done", 32'(done_b), 32'd0);
        @(negedge clk);
        checkOutput("lat3 i1",   alu_i1_b, 32'd4);
        checkOutput("lat3 i2",   alu_i2_b, 32'hFFFF_FFFF);
        checkOutput("lat3 exec done", 32'(done_b), 32'd0);
        @(negedge clk);
        checkOutput("lat3 done",  32'(done_b),  32'd1);
        checkOutput("lat3 rf_we", 32'(we_b),    32'd1);
        checkOutput("lat3 waddr", 32'(waddr_b), 32'd12);
        checkOutput("lat3 wdata", wdata_b,      32'd3);
        @(negedge clk);
        checkOutput("lat3 done end", 32'(done_b),  32'd0);
        checkOutput("lat3 ready",    32'(ready_b), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
